// File: rtl/vip_csr_slave.sv
// Avalon-MM register responder for the scaler / mixer / CVO bank map.
// Writes land in per-bank shadows; an armed bank commits shadow -> active on frame_start.
module vip_csr_slave #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned FIELD_W     = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  input  logic               read,
  output logic [31:0]        readdata,
  output logic               readdatavalid,
  output logic               waitrequest,
  input  logic               frame_start,
  output logic [FIELD_W-1:0] scl_out_w,
  output logic [FIELD_W-1:0] scl_out_h,
  output logic [FIELD_W-1:0] mix_bkg_w,
  output logic [FIELD_W-1:0] mix_bkg_h,
  output logic [FIELD_W-1:0] mix_pos_x,
  output logic [FIELD_W-1:0] mix_pos_y,
  output logic               mix_en0,
  output logic [FIELD_W-1:0] cvo_hact,
  output logic [FIELD_W-1:0] cvo_vact,
  output logic [FIELD_W-1:0] cvo_hfp,
  output logic [FIELD_W-1:0] cvo_hs,
  output logic [FIELD_W-1:0] cvo_hblank,
  output logic [FIELD_W-1:0] cvo_vfp,
  output logic [FIELD_W-1:0] cvo_vs,
  output logic [FIELD_W-1:0] cvo_vblank,
  output logic               cvo_interlaced,
  output logic               cvo_valid,
  output logic               scl_run,
  output logic               mix_run,
  output logic               cvo_run,
  output logic [2:0]         commit
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CntW-1:0]    wait_q;
  logic               acc_wr, acc_rd;
  logic [2:0]         go_wr, commit_d, pend_q, run_q;
  logic [FIELD_W-1:0] fld;
  logic [31:0]        rd_mux;

  // Shadow registers
  logic [FIELD_W-1:0] scl_w_q, scl_h_q;
  logic [FIELD_W-1:0] mix_bw_q, mix_bh_q, mix_px_q, mix_py_q;
  logic               mix_en0_q;
  logic [FIELD_W-1:0] cvo_bsel_q, cvo_hact_q, cvo_vact_q, cvo_hfp_q, cvo_hs_q;
  logic [FIELD_W-1:0] cvo_hblank_q, cvo_vfp_q, cvo_vs_q, cvo_vblank_q;
  logic               cvo_intl_q, cvo_valid_q;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:FIELD_W];

  assign waitrequest = (wait_q != '0);
  assign acc_wr      = write && !waitrequest;
  assign acc_rd      = read && !write && !waitrequest;
  assign fld         = writedata[FIELD_W-1:0];

  assign go_wr[0] = acc_wr && (address == 9'h000);
  assign go_wr[1] = acc_wr && (address == 9'h080);
  assign go_wr[2] = acc_wr && (address == 9'h100);

  // A Go write in a frame_start cycle takes precedence over the commit.
  assign commit_d = {3{frame_start}} & pend_q & ~go_wr;

  assign scl_run = run_q[0];
  assign mix_run = run_q[1];
  assign cvo_run = run_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q        <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      if (acc_wr || acc_rd) begin
        wait_q <= CntW'(WAIT_CYCLES);
      end else if (wait_q != '0) begin
        wait_q <= wait_q - CntW'(1);
      end
      readdatavalid <= acc_rd;
      if (acc_rd) begin
        readdata <= rd_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      run_q  <= '0;
      commit <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (go_wr[i]) begin
          pend_q[i] <= writedata[0];
          if (!writedata[0]) begin
            run_q[i] <= 1'b0;
          end
        end else if (commit_d[i]) begin
          pend_q[i] <= 1'b0;
          run_q[i]  <= 1'b1;
        end
      end
      commit <= commit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_w_q      <= '0;
      scl_h_q      <= '0;
      mix_bw_q     <= '0;
      mix_bh_q     <= '0;
      mix_px_q     <= '0;
      mix_py_q     <= '0;
      mix_en0_q    <= 1'b0;
      cvo_bsel_q   <= '0;
      cvo_intl_q   <= 1'b0;
      cvo_hact_q   <= '0;
      cvo_vact_q   <= '0;
      cvo_hfp_q    <= '0;
      cvo_hs_q     <= '0;
      cvo_hblank_q <= '0;
      cvo_vfp_q    <= '0;
      cvo_vs_q     <= '0;
      cvo_vblank_q <= '0;
      cvo_valid_q  <= 1'b0;
    end else if (acc_wr) begin
      case (address)
        9'h003:  scl_w_q      <= fld;
        9'h004:  scl_h_q      <= fld;
        9'h083:  mix_bw_q     <= fld;
        9'h084:  mix_bh_q     <= fld;
        9'h088:  mix_px_q     <= fld;
        9'h089:  mix_py_q     <= fld;
        9'h08A:  mix_en0_q    <= writedata[0];
        9'h104:  cvo_bsel_q   <= fld;
        9'h105:  cvo_intl_q   <= writedata[0];
        9'h106:  cvo_hact_q   <= fld;
        9'h107:  cvo_vact_q   <= fld;
        9'h109:  cvo_hfp_q    <= fld;
        9'h10A:  cvo_hs_q     <= fld;
        9'h10B:  cvo_hblank_q <= fld;
        9'h10C:  cvo_vfp_q    <= fld;
        9'h10D:  cvo_vs_q     <= fld;
        9'h10E:  cvo_vblank_q <= fld;
        9'h11E:  cvo_valid_q  <= writedata[0];
        default: ;
      endcase
    end
  end

  // Commit copies the pre-write shadow, so a coincident field write only reaches the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_out_w      <= '0;
      scl_out_h      <= '0;
      mix_bkg_w      <= '0;
      mix_bkg_h      <= '0;
      mix_pos_x      <= '0;
      mix_pos_y      <= '0;
      mix_en0        <= 1'b0;
      cvo_hact       <= '0;
      cvo_vact       <= '0;
      cvo_hfp        <= '0;
      cvo_hs         <= '0;
      cvo_hblank     <= '0;
      cvo_vfp        <= '0;
      cvo_vs         <= '0;
      cvo_vblank     <= '0;
      cvo_interlaced <= 1'b0;
      cvo_valid      <= 1'b0;
    end else begin
      if (commit_d[0]) begin
        scl_out_w <= scl_w_q;
        scl_out_h <= scl_h_q;
      end
      if (commit_d[1]) begin
        mix_bkg_w <= mix_bw_q;
        mix_bkg_h <= mix_bh_q;
        mix_pos_x <= mix_px_q;
        mix_pos_y <= mix_py_q;
        mix_en0   <= mix_en0_q;
      end
      if (commit_d[2]) begin
        cvo_hact       <= cvo_hact_q;
        cvo_vact       <= cvo_vact_q;
        cvo_hfp        <= cvo_hfp_q;
        cvo_hs         <= cvo_hs_q;
        cvo_hblank     <= cvo_hblank_q;
        cvo_vfp        <= cvo_vfp_q;
        cvo_vs         <= cvo_vs_q;
        cvo_vblank     <= cvo_vblank_q;
        cvo_interlaced <= cvo_intl_q;
        cvo_valid      <= cvo_valid_q;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      9'h000:  rd_mux[0]           = pend_q[0];
      9'h001:  rd_mux[1:0]         = {pend_q[0], run_q[0]};
      9'h003:  rd_mux[FIELD_W-1:0] = scl_w_q;
      9'h004:  rd_mux[FIELD_W-1:0] = scl_h_q;
      9'h080:  rd_mux[0]           = pend_q[1];
      9'h081:  rd_mux[1:0]         = {pend_q[1], run_q[1]};
      9'h083:  rd_mux[FIELD_W-1:0] = mix_bw_q;
      9'h084:  rd_mux[FIELD_W-1:0] = mix_bh_q;
      9'h088:  rd_mux[FIELD_W-1:0] = mix_px_q;
      9'h089:  rd_mux[FIELD_W-1:0] = mix_py_q;
      9'h08A:  rd_mux[0]           = mix_en0_q;
      9'h100:  rd_mux[0]           = pend_q[2];
      9'h101:  rd_mux[1:0]         = {pend_q[2], run_q[2]};
      9'h104:  rd_mux[FIELD_W-1:0] = cvo_bsel_q;
      9'h105:  rd_mux[0]           = cvo_intl_q;
      9'h106:  rd_mux[FIELD_W-1:0] = cvo_hact_q;
      9'h107:  rd_mux[FIELD_W-1:0] = cvo_vact_q;
      9'h109:  rd_mux[FIELD_W-1:0] = cvo_hfp_q;
      9'h10A:  rd_mux[FIELD_W-1:0] = cvo_hs_q;
      9'h10B:  rd_mux[FIELD_W-1:0] = cvo_hblank_q;
      9'h10C:  rd_mux[FIELD_W-1:0] = cvo_vfp_q;
      9'h10D:  rd_mux[FIELD_W-1:0] = cvo_vs_q;
      9'h10E:  rd_mux[FIELD_W-1:0] = cvo_vblank_q;
      9'h11E:  rd_mux[0]           = cvo_valid_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vip_csr_slave.sv
// Bench for vip_csr_slave: directed test-plan sequences plus random traffic, all checked
// every cycle against an array-based model of the bank map.
module tb_vip_csr_slave;

  localparam int unsigned WC = 2;
  localparam int unsigned FW = 12;

  logic          clk = 1'b0;
  logic          reset, write, read, frame_start;
  logic [8:0]    address;
  logic [31:0]   writedata, readdata;
  logic          readdatavalid, waitrequest;
  logic [FW-1:0] scl_out_w, scl_out_h, mix_bkg_w, mix_bkg_h, mix_pos_x, mix_pos_y;
  logic [FW-1:0] cvo_hact, cvo_vact, cvo_hfp, cvo_hs, cvo_hblank, cvo_vfp, cvo_vs, cvo_vblank;
  logic          mix_en0, cvo_interlaced, cvo_valid, scl_run, mix_run, cvo_run;
  logic [2:0]    commit;

  int checks = 0;
  int errors = 0;

  // Model state: shadow/active per bank and register offset.
  logic [31:0] sh  [3][128];
  logic [31:0] act [3][128];
  int          m_wait;
  logic [2:0]  m_pend, m_run, m_commit;
  logic        m_rdv;
  logic [31:0] m_rd;

  vip_csr_slave #(.WAIT_CYCLES(WC), .FIELD_W(FW)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .frame_start(frame_start),
    .scl_out_w(scl_out_w), .scl_out_h(scl_out_h),
    .mix_bkg_w(mix_bkg_w), .mix_bkg_h(mix_bkg_h), .mix_pos_x(mix_pos_x),
    .mix_pos_y(mix_pos_y), .mix_en0(mix_en0),
    .cvo_hact(cvo_hact), .cvo_vact(cvo_vact), .cvo_hfp(cvo_hfp), .cvo_hs(cvo_hs),
    .cvo_hblank(cvo_hblank), .cvo_vfp(cvo_vfp), .cvo_vs(cvo_vs), .cvo_vblank(cvo_vblank),
    .cvo_interlaced(cvo_interlaced), .cvo_valid(cvo_valid),
    .scl_run(scl_run), .mix_run(mix_run), .cvo_run(cvo_run), .commit(commit)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Register width: 0 unmapped, 1 single-bit flag, FW geometry/timing field.
  function automatic int fw(input int b, input int o);
    int r;
    r = 0;
    case (b)
      0: if (o inside {3, 4}) r = FW;
      1: begin
        if (o inside {3, 4, 8, 9}) r = FW;
        else if (o == 10) r = 1;
      end
      2: begin
        if (o inside {4, 6, 7, 9, 10, 11, 12, 13, 14}) r = FW;
        else if (o inside {5, 30}) r = 1;
      end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rd_val(input int b, input int o);
    logic [31:0] r;
    r = 32'h0;
    if (b < 3) begin
      if (o == 0) r = {31'h0, m_pend[b]};
      else if (o == 1) r = {30'h0, m_pend[b], m_run[b]};
      else if (fw(b, o) != 0) r = sh[b][o];
    end
    return r;
  endfunction

  task automatic model_step(input bit w, input bit r, input logic [8:0] a,
                            input logic [31:0] wd, input bit fs, input bit rst);
    int b, o;
    bit aw, ar;
    logic [2:0] c;
    if (rst) begin
      m_wait = 0; m_pend = '0; m_run = '0; m_commit = '0; m_rdv = 1'b0; m_rd = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 128; j++) begin
          sh[i][j] = '0;
          act[i][j] = '0;
        end
    end else begin
      b  = int'(a[8:7]);
      o  = int'(a[6:0]);
      aw = w && (m_wait == 0);
      ar = r && !w && (m_wait == 0);
      m_wait = (aw || ar) ? WC : ((m_wait > 0) ? m_wait - 1 : 0);
      m_rdv  = ar;
      if (ar) m_rd = rd_val(b, o);
      c = '0;
      for (int k = 0; k < 3; k++) begin
        c[k] = fs && m_pend[k] && !(aw && b == k && o == 0);
        if (c[k]) begin
          for (int j = 0; j < 128; j++) act[k][j] = sh[k][j];
          m_pend[k] = 1'b0;
          m_run[k]  = 1'b1;
        end
      end
      m_commit = c;
      if (aw && b < 3 && o == 0) begin
        m_pend[b] = wd[0];
        if (!wd[0]) m_run[b] = 1'b0;
      end else if (aw && b < 3 && fw(b, o) != 0) begin
        sh[b][o] = wd & ((32'h1 << fw(b, o)) - 32'h1);
      end
    end
  endtask

  task automatic compare_all();
    check("waitrequest", {31'h0, waitrequest}, {31'h0, m_wait != 0});
    check("readdatavalid", {31'h0, readdatavalid}, {31'h0, m_rdv});
    if (m_rdv) check("readdata", readdata, m_rd);
    check("commit", {29'h0, commit}, {29'h0, m_commit});
    check("run", {29'h0, cvo_run, mix_run, scl_run}, {29'h0, m_run});
    check("scl_out_w", 32'(scl_out_w), act[0][3]);
    check("scl_out_h", 32'(scl_out_h), act[0][4]);
    check("mix_bkg_w", 32'(mix_bkg_w), act[1][3]);
    check("mix_bkg_h", 32'(mix_bkg_h), act[1][4]);
    check("mix_pos_x", 32'(mix_pos_x), act[1][8]);
    check("mix_pos_y", 32'(mix_pos_y), act[1][9]);
    check("mix_en0", {31'h0, mix_en0}, act[1][10]);
    check("cvo_interlaced", {31'h0, cvo_interlaced}, act[2][5]);
    check("cvo_hact", 32'(cvo_hact), act[2][6]);
    check("cvo_vact", 32'(cvo_vact), act[2][7]);
    check("cvo_hfp", 32'(cvo_hfp), act[2][9]);
    check("cvo_hs", 32'(cvo_hs), act[2][10]);
    check("cvo_hblank", 32'(cvo_hblank), act[2][11]);
    check("cvo_vfp", 32'(cvo_vfp), act[2][12]);
    check("cvo_vs", 32'(cvo_vs), act[2][13]);
    check("cvo_vblank", 32'(cvo_vblank), act[2][14]);
    check("cvo_valid", {31'h0, cvo_valid}, act[2][30]);
  endtask

  // Drive one cycle of inputs, advance the model, then compare on the falling edge.
  task automatic step(input bit w, input bit r, input logic [8:0] a, input logic [31:0] wd,
                      input bit fs, input bit rst);
    write = w; read = r; address = a; writedata = wd; frame_start = fs; reset = rst;
    model_step(w, r, a, wd, fs, rst);
    @(negedge clk);
    compare_all();
  endtask

  // Hold a write until accepted; frame_start (if requested) accompanies the accept cycle.
  task automatic bus_write(input logic [8:0] a, input logic [31:0] wd, input bit fs,
                           output int n);
    bit acc;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 16) begin
      acc = (m_wait == 0);
      step(1'b1, 1'b0, a, wd, acc ? fs : 1'b0, 1'b0);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr 0x%0h not accepted within %0d cycles", a, n);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] wd);
    int n;
    bus_write(a, wd, 1'b0, n);
  endtask

  task automatic bus_read(input logic [8:0] a);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 16) begin
      acc = (m_wait == 0);
      step(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr 0x%0h not accepted within %0d cycles", a, n);
    end
  endtask

  task automatic idle(input bit fs);
    step(1'b0, 1'b0, 9'h0, 32'h0, fs, 1'b0);
  endtask

  int offs [15] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 30};

  initial begin
    int n;
    int b, o;
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1);
    check("lit_reset_wait", {31'h0, waitrequest}, 32'h0);
    check("lit_reset_scl_w", 32'(scl_out_w), 32'h0);

    // Handshake timing
    idle(1'b0);
    bus_write(9'h003, 32'h500, 1'b0, n);
    check("lit_wait_after_accept", {31'h0, waitrequest}, 32'h1);
    bus_write(9'h004, 32'h123, 1'b0, n);
    check("lit_held_write_cycles", n, 32'd3);

    // Scaler commit
    wr(9'h003, 32'd800);
    wr(9'h004, 32'd600);
    wr(9'h000, 32'h1);
    check("lit_scl_pre_commit", 32'(scl_out_w), 32'h0);
    bus_read(9'h001);
    check("lit_scl_status_pend", readdata, 32'h2);
    idle(1'b1);
    check("lit_scl_commit", {29'h0, commit}, 32'h1);
    check("lit_scl_w", 32'(scl_out_w), 32'd800);
    check("lit_scl_h", 32'(scl_out_h), 32'd600);
    check("lit_scl_run", {31'h0, scl_run}, 32'h1);
    idle(1'b0);
    check("lit_commit_pulse", {29'h0, commit}, 32'h0);
    bus_read(9'h001);
    check("lit_scl_status_run", readdata, 32'h1);

    // Full CVO set
    wr(9'h106, 32'd1280); wr(9'h107, 32'd720); wr(9'h109, 32'd110); wr(9'h10A, 32'd40);
    wr(9'h10B, 32'd370);  wr(9'h10C, 32'd5);   wr(9'h10D, 32'd5);   wr(9'h10E, 32'd30);
    wr(9'h11E, 32'h1);    wr(9'h100, 32'h1);
    idle(1'b1);
    check("lit_cvo_commit", {29'h0, commit}, 32'h4);
    check("lit_cvo_hact", 32'(cvo_hact), 32'd1280);
    check("lit_cvo_hblank", 32'(cvo_hblank), 32'd370);
    check("lit_cvo_vblank", 32'(cvo_vblank), 32'd30);
    check("lit_cvo_valid", {31'h0, cvo_valid}, 32'h1);
    check("lit_cvo_scl_kept", 32'(scl_out_w), 32'd800);
    check("lit_cvo_mix_kept", 32'(mix_bkg_w), 32'h0);

    // Go coincident with frame_start, then field write coincident with commit
    wr(9'h083, 32'd100);
    bus_write(9'h080, 32'h1, 1'b1, n);
    check("lit_go_fs_no_commit", {29'h0, commit}, 32'h0);
    idle(1'b1);
    check("lit_mix_commit", {29'h0, commit}, 32'h2);
    check("lit_mix_bkg_w", 32'(mix_bkg_w), 32'd100);
    wr(9'h083, 32'd200);
    wr(9'h080, 32'h1);
    bus_write(9'h083, 32'd300, 1'b1, n);
    check("lit_mix_commit_old", 32'(mix_bkg_w), 32'd200);
    bus_read(9'h083);
    check("lit_mix_shadow_new", readdata, 32'd300);

    // Truncation, unmapped bank, Go=0
    wr(9'h083, 32'hFFFFF123);
    bus_read(9'h083);
    check("lit_trunc", readdata, 32'h123);
    wr(9'h1A5, 32'hDEADBEEF);
    bus_read(9'h1A5);
    check("lit_bank3_read", readdata, 32'h0);
    wr(9'h080, 32'h0);
    check("lit_go0_run", {31'h0, mix_run}, 32'h0);
    check("lit_go0_held", 32'(mix_bkg_w), 32'd200);

    // Reset while pending and stalled
    wr(9'h000, 32'h1);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b1);
    check("lit_rst_wait", {31'h0, waitrequest}, 32'h0);
    check("lit_rst_scl_w", 32'(scl_out_w), 32'h0);
    check("lit_rst_cvo_hact", 32'(cvo_hact), 32'h0);
    idle(1'b0);
    idle(1'b1);
    check("lit_rst_no_commit", {29'h0, commit}, 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      b = $urandom_range(0, 3);
      o = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : offs[$urandom_range(0, 14)];
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 9'((b << 7) | o),
           ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vip_csr_slave.md
Name: vip_csr_slave

Overview:
- Avalon-MM register responder for the scaler, mixer and clocked-video-output (CVO) bank map. It is the receiving end of the config master's write stream.
- Data writes land in per-bank shadow registers. A Go write arms the bank, and the shadow is committed to the active outputs on the next frame_start pulse.
- Sits between the config writer and video-pipeline stand-ins (simulation models, soft scaler/mixer/timing generators).

Parameters:
WAIT_CYCLES, 2, cycles waitrequest stays high after each accepted transfer (0 = never stalls)
FIELD_W, 12, width of every geometry/timing output field

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
address  in  9  word address; [8:7] bank (0 scaler, 1 mixer, 2 CVO, 3 unmapped), [6:0] register
write  in  1  write request
writedata  in  32  write data
read  in  1  read request
readdata  out  32  read data
readdatavalid  out  1  one-cycle pulse, readdata valid
waitrequest  out  1  stall; transfer accepted only when (write|read) && !waitrequest
frame_start  in  1  one-cycle pulse at frame boundary; commit point
scl_out_w, scl_out_h  out  FIELD_W  scaler output size
mix_bkg_w, mix_bkg_h, mix_pos_x, mix_pos_y  out  FIELD_W  mixer background size / layer-0 position
mix_en0  out  1  mixer layer-0 enable
cvo_hact, cvo_vact, cvo_hfp, cvo_hs, cvo_hblank, cvo_vfp, cvo_vs, cvo_vblank  out  FIELD_W  CVO timing
cvo_interlaced, cvo_valid  out  1  CVO mode flags
scl_run, mix_run, cvo_run  out  1  bank running (committed at least once since last stop)
commit  out  3  one-cycle pulse per bank [0 scl, 1 mix, 2 cvo] when shadow copied to active

Behaviour:
- Reset: all active outputs, shadows, pending flags, run bits, commit, readdata, readdatavalid and waitrequest = 0; wait counter = 0. Reset mid-transfer drops the transfer.
- Handshake:
  - waitrequest = (wait counter != 0), driven from the register.
  - An accepted transfer loads the counter with WAIT_CYCLES, so waitrequest rises the next cycle.
  - The counter decrements to 0.
  - write and read together: the write takes priority and the read is ignored.
- Register map (offset within bank):
  - Scaler (0x000): 0x03 out_w, 0x04 out_h.
  - Mixer (0x080): 0x03 bkg_w, 0x04 bkg_h, 0x08 pos_x, 0x09 pos_y, 0x0A en0 (bit 0).
  - CVO (0x100): 0x04 bank select (stored, readback only), 0x05 interlaced (bit 0), 0x06 hact, 0x07 vact, 0x09 hfp, 0x0A hs, 0x0B hblank, 0x0C vfp, 0x0D vs, 0x0E vblank, 0x1E valid (bit 0).
  - Offset 0x00 of each bank: Go/control. Offset 0x01: status, read-only.
- Field writes store writedata[FIELD_W-1:0]; upper bits are discarded. Writes to unmapped offsets, bank 3, or status are ignored.
- Go write:
  - writedata[0]=1 sets the bank's pending flag.
  - writedata[0]=0 clears pending and run immediately. Active outputs hold their values.
- Commit:
  - Triggered on a frame_start cycle with pending=1, independently per bank.
  - Active <= shadow, pending <= 0, run <= 1, commit[bank] pulses that same cycle (registered, visible next cycle).
- Simultaneous events:
  - A Go=1 write in a frame_start cycle does not commit that frame; pending is set and the commit happens at the next frame_start.
  - A field write in a commit cycle: the commit uses the pre-write shadow, and the new value lands in the shadow only.
  - A Go=0 write in a frame_start cycle clears pending, so no commit occurs.
- Reads:
  - readdata is registered and readdatavalid pulses the cycle after acceptance (latency 1).
  - Field offsets return the zero-extended shadow value.
  - Status returns {30'b0, pending, run}.
  - Go returns {31'b0, pending}.
  - Unmapped offsets return 0.
- frame_start with nothing pending: no effect.

Test Plan:
- Reset, then WAIT_CYCLES=2 write 0x003=0x500: waitrequest high cycles 1-2 after accept, low at 3; a second write held during stall is accepted only on cycle 3.
- Write scaler 0x003=800, 0x004=600, Go=1, no frame_start -> scl_out_w/h stay 0, status reads 0x2; pulse frame_start -> scl_out_w=800, scl_out_h=600, commit=3'b001 one cycle, scl_run=1, status 0x1.
- Program full CVO set (hact 1280, vact 720, hfp 110, hs 40, hblank 370, vfp 5, vs 5, vblank 30, valid 1), Go, frame_start -> all cvo_* match; mixer/scaler outputs untouched, commit=3'b100.
- Go write coincident with frame_start -> no commit that cycle; commit on next frame_start; field write coincident with commit -> active keeps old value, readback shows new value.
- Write 0x083=0xFFFFF123 -> readback 0x123; write 0x1A5 (bank 3) and read it -> 0, no output change; Go=0 on running mixer -> mix_run=0, outputs held.
- Assert reset while pending=1 and waitrequest=1 -> next cycle all outputs 0, waitrequest 0, subsequent frame_start causes no commit.
